keysw_in: RTL and testbench

- Input-side peripheral for the SOCkit board: the processor-to-user direction drives the LEDs; this block carries user-to-processor inputs from the 4 push-buttons (KEY, active-low) and 4 slide switches (SW).
- Synchronizes and debounces every input, detects button presses, holds sticky press flags, and counts presses.
- Presents a small read-only register window to the MIPS data-memory decode with one-cycle registered read latency, plus a level interrupt request.

---
 rtl/keysw_in.sv | 148 ++++++++++++++
 tb/tb_keysw_in.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keysw_in.sv
// keysw_in: user-input side of the SOCkit board I/O.
// Brings the four push-buttons and four slide switches into the clock domain,
// debounces them, records button presses as sticky flags and a press counter,
// and exposes them through a small read-only register window with a level irq.
module keysw_in #(
  parameter int NKEYS           = 4,
  parameter int NSW             = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic [NSW-1:0]   sw,
  input  logic             rd_en,
  input  logic [1:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic             irq
);

  // Keys and switches share one synchronizer/debounce path; keys sit in the
  // low bits. Idle level: keys released (1), switches down (0).
  localparam int               NIN   = NKEYS + NSW;
  localparam logic [NIN-1:0]   IDLE  = {{NSW{1'b0}}, {NKEYS{1'b1}}};
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               EVT_W = $clog2(NKEYS + 1);

  typedef enum logic [1:0] {
    ADDR_LEVEL  = 2'd0,
    ADDR_STICKY = 2'd1,
    ADDR_COUNT  = 2'd2,
    ADDR_ZERO   = 2'd3
  } addr_e;

  logic [NIN-1:0]             raw;
  logic [NIN-1:0]             sync1;
  logic [NIN-1:0]             sync2;
  logic [NIN-1:0]             q;
  logic [NIN-1:0]             q_nxt;
  logic [NIN-1:0][CNT_W-1:0]  cnt;
  logic [NIN-1:0][CNT_W-1:0]  cnt_nxt;

  logic [NKEYS-1:0]           q_key;
  logic [NKEYS-1:0]           q_key_nxt;
  logic [NSW-1:0]             q_sw;
  logic [NKEYS-1:0]           pressed;
  logic [NKEYS-1:0]           press_evt;
  logic [NKEYS-1:0]           sticky;
  logic [EVT_W-1:0]           evt_num;
  logic [15:0]                press_count;
  logic                       read_clr;
  logic [31:0]                rd_next;

  assign raw       = {sw, key_n};
  assign q_key     = q[NKEYS-1:0];
  assign q_key_nxt = q_nxt[NKEYS-1:0];
  assign q_sw      = q[NIN-1:NKEYS];
  assign pressed   = ~q_key;
  assign read_clr  = rd_en && (addr_e'(rd_addr) == ADDR_STICKY);

  // Two-flop synchronizer for every raw input bit.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce next state: a bit follows the input only after it has differed
  // from the stable level for DEBOUNCE_CYCLES consecutive cycles.
  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    for (int i = 0; i < NIN; i++) begin
      if (sync2[i] == q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == TERM) begin
        q_nxt[i]   = sync2[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced levels, counters and the one-cycle press pulses.
  // NOTE: the counter array is reset because a partial count must never
  // survive a reset and let a bouncing input through early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= IDLE;
      cnt       <= '0;
      press_evt <= '0;
    end else begin
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      press_evt <= q_key & ~q_key_nxt;
    end
  end

  // Number of keys pressed in this cycle's event pulse.
  always_comb begin
    evt_num = '0;
    for (int i = 0; i < NKEYS; i++) begin
      evt_num = evt_num + EVT_W'(press_evt[i]);
    end
  end

  // Sticky flags (set beats read-clear), press counter and irq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky      <= '0;
      press_count <= '0;
      irq         <= 1'b0;
    end else begin
      sticky      <= (read_clr ? '0 : sticky) | press_evt;
      press_count <= press_count + 16'(evt_num);
      irq         <= |sticky;
    end
  end

  // Register window decode; unused high bits read as zero.
  always_comb begin
    rd_next = '0;
    case (addr_e'(rd_addr))
      ADDR_LEVEL:  rd_next[NIN-1:0]   = {q_sw, pressed};
      ADDR_STICKY: rd_next[NKEYS-1:0] = sticky;
      ADDR_COUNT:  rd_next[15:0]      = press_count;
      default:     rd_next            = '0;
    endcase
  end

  // Read data register: loads on a strobe, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_keysw_in.sv
// Testbench for keysw_in with a short debounce window. Directed vectors with
// hand-computed expectations, a few multi-cycle corner sequences, and random
// stimulus compared every cycle against a behavioural model.
module tb_keysw_in;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [3:0]  sw;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        irq;

  int total = 0;
  int bad   = 0;

  keysw_in #(
    .NKEYS(4),
    .NSW(4),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .sw(sw),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: inputs reach the debouncer two cycles late; a bit takes
  // the new level once the last DEB synchronized samples all disagree with it.
  logic [7:0]  m_s1, m_s2, m_q;
  logic [7:0]  hist[$];
  logic [3:0]  m_evt, m_sticky;
  logic [15:0] m_count;
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic model_reset();
    m_s1 = 8'h0F; m_s2 = 8'h0F; m_q = 8'h0F;
    hist.delete();
    m_evt = '0; m_sticky = '0; m_count = '0; m_rd = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] s, q_new;
    logic [3:0] new_evt;
    bit         all_diff;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = {sw, key_n};
    hist.push_back(s);
    if (hist.size() > DEB) void'(hist.pop_front());
    q_new = m_q;
    if (hist.size() == DEB) begin
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][b] == m_q[b]) all_diff = 1'b0;
        if (all_diff) q_new[b] = ~m_q[b];
      end
    end
    new_evt = m_q[3:0] & ~q_new[3:0];
    if (rd_en) begin
      case (rd_addr)
        2'd0:    m_rd = {24'h0, m_q[7:4], ~m_q[3:0]};
        2'd1:    m_rd = {28'h0, m_sticky};
        2'd2:    m_rd = {16'h0, m_count};
        default: m_rd = 32'h0;
      endcase
    end
    m_irq    = |m_sticky;
    m_sticky = ((rd_en && rd_addr == 2'd1) ? 4'h0 : m_sticky) | m_evt;
    m_count  = m_count + 16'($countones(m_evt));
    m_evt    = new_evt;
    m_q      = q_new;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model alongside the DUT, then compare just after the edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
    check("model_rd_data", rd_data, m_rd);
    check("model_irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_read(input logic [1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    cycle();
    rd_en   = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  key_n;
    logic [3:0]  sw;
    int          idle;
    logic [1:0]  addr;
    logic [31:0] exp_data;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // inputs held for 'idle' cycles, then one read; values after the read edge
    vecs[0]  = '{4'hF, 4'h0, 20, 2'd0, 32'h0,  1'b0};
    vecs[1]  = '{4'hF, 4'h0,  0, 2'd1, 32'h0,  1'b0};
    vecs[2]  = '{4'hF, 4'h0,  0, 2'd2, 32'h0,  1'b0};
    vecs[3]  = '{4'hF, 4'h0,  0, 2'd3, 32'h0,  1'b0};
    vecs[4]  = '{4'hE, 4'h0,  6, 2'd0, 32'h1,  1'b0};  // key0 debounced
    vecs[5]  = '{4'hE, 4'h0,  0, 2'd1, 32'h1,  1'b1};  // sticky, irq up
    vecs[6]  = '{4'hE, 4'h0,  0, 2'd1, 32'h0,  1'b0};  // cleared, irq down
    vecs[7]  = '{4'hF, 4'h0, 10, 2'd1, 32'h0,  1'b0};  // release: no event
    vecs[8]  = '{4'hF, 4'h0,  0, 2'd2, 32'h1,  1'b0};
    vecs[9]  = '{4'hF, 4'h0,  0, 2'd0, 32'h0,  1'b0};
    vecs[10] = '{4'h5, 4'h0,  8, 2'd1, 32'hA,  1'b1};  // keys 1,3 together
    vecs[11] = '{4'h5, 4'h0,  0, 2'd2, 32'h3,  1'b0};
    vecs[12] = '{4'h5, 4'h5,  7, 2'd0, 32'h5A, 1'b0};
    vecs[13] = '{4'hF, 4'h0, 10, 2'd0, 32'h0,  1'b0};
    vecs[14] = '{4'hF, 4'h0,  0, 2'd2, 32'h3,  1'b0};

    reset = 1'b0; key_n = 4'hF; sw = 4'h0; rd_en = 1'b0; rd_addr = 2'd0;
    model_reset();
    #1;
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    repeat (3) cycle();
    reset = 1'b1;

    foreach (vecs[v]) begin
      key_n = vecs[v].key_n;
      sw    = vecs[v].sw;
      idle(vecs[v].idle);
      do_read(vecs[v].addr);
      check($sformatf("vec%0d_data", v), rd_data, vecs[v].exp_data);
      check($sformatf("vec%0d_irq", v), {31'h0, irq}, {31'h0, vecs[v].exp_irq});
    end

    // Bouncing key2 must yield exactly one press.
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 4'hB : 4'hF;
      idle(2);
    end
    key_n = 4'hB;
    idle(8);
    do_read(2'd1);
    check("bounce_sticky", rd_data, 32'h4);
    do_read(2'd2);
    check("bounce_count", rd_data, 32'h4);
    key_n = 4'hF;
    idle(10);

    // Read-clear of sticky in the same cycle as a key0 press pulse.
    key_n = 4'hE;
    idle(6);
    do_read(2'd1);
    check("aligned_read_old", rd_data, 32'h0);
    do_read(2'd1);
    check("aligned_read_new", rd_data, 32'h1);
    check("aligned_irq", {31'h0, irq}, 32'h1);
    key_n = 4'hF;
    idle(10);
    do_read(2'd2);
    check("count_before_wrap", rd_data, 32'h5);

    // Counter wrap from 0xFFFF.
    force dut.press_count = 16'hFFFF;
    idle(1);
    release dut.press_count;
    m_count = 16'hFFFF;
    do_read(2'd2);
    check("count_preload", rd_data, 32'hFFFF);
    key_n = 4'hE;
    idle(8);
    do_read(2'd2);
    check("count_wrap", rd_data, 32'h0);
    key_n = 4'hF;
    idle(10);

    // Random stimulus against the model.
    for (int n = 0; n < 250; n++) begin
      int hold;
      key_n = 4'($urandom);
      sw    = 4'($urandom);
      hold  = $urandom_range(1, 10);
      for (int h = 0; h < hold; h++) begin
        rd_en   = ($urandom_range(0, 3) == 0);
        rd_addr = 2'($urandom);
        cycle();
      end
    end
    rd_en = 1'b0;

    // Reset while sticky is set and a release is mid-debounce.
    key_n = 4'h0; sw = 4'h0;
    idle(12);
    do_read(2'd0);
    check("all_pressed", rd_data, 32'hF);
    key_n = 4'hF;
    idle(3);
    reset = 1'b0;
    model_reset();
    #1;
    check("midreset_rd_data", rd_data, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    idle(2);
    reset = 1'b1;
    idle(20);
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a));
      check($sformatf("post_reset_addr%0d", a), rd_data, 32'h0);
      check($sformatf("post_reset_irq%0d", a), {31'h0, irq}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
